fifo_read_ctrl: RTL
===================

FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning FIFO read data width.
REQ-002 SHALL have parameter LVL_W, default 6, meaning FIFO level/count width.
REQ-003 SHALL have parameter AEMPTY_DEF, default 5, meaning aempty_value driven while cfg_load has never been seen.
REQ-004 SHALL have port rclk  input  1  read-domain clock; the only clock; all logic on rising edge.
REQ-005 SHALL have port hw_rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port sw_rst  input  1  synchronous active-high soft clear.
REQ-007 SHALL have port enable  input  1  permits new FIFO reads.
REQ-008 SHALL have port cfg_load / cfg_aempty  input  1 / 5  load strobe and new almost-empty threshold.
REQ-009 SHALL have port rdempty, rd_almost_empty, underflow  input  1 each  FIFO read-side status.
REQ-010 SHALL have port rd_level  input  LVL_W  FIFO read-side occupancy.
REQ-011 SHALL have port read_data  input  DATA_W  FIFO output, valid exactly 1 cycle after read_enable.
REQ-012 SHALL have port read_enable  output  1  FIFO pop request.
REQ-013 SHALL have port aempty_value  output  5  registered threshold to FIFO.
REQ-014 SHALL have port m_data / m_valid / m_ready  output DATA_W / output 1 / input 1  downstream stream; transfer when m_valid && m_ready.
REQ-015 SHALL have port busy  output  1  high when state != IDLE.
REQ-016 SHALL have port err_underflow  output  1  sticky flag.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN: IDLE->RUN on enable; RUN->DRAIN on !enable; DRAIN->IDLE when no read in flight and skid buffer empty; DRAIN->RUN on enable.
REQ-018 SHALL hold a 2-entry skid buffer; m_data/m_valid reflect the head entry, registered.
REQ-019 SHALL assert read_enable only in RUN, with !rdempty, and buffer occupancy + in-flight reads < 2.
REQ-020 SHALL, because rdempty lags one cycle, not issue a read in the cycle after a read when rd_level <= 1.
REQ-021 SHALL never assert read_enable while rdempty is high.
REQ-022 SHALL capture read_data into the buffer in the cycle after read_enable (1-cycle latency); earliest m_valid is 2 cycles after read_enable.
REQ-023 SHALL, with m_ready held high and rd_level >= 2, sustain one read_enable and one transfer per cycle.
REQ-024 SHALL, on a simultaneous capture and transfer, keep occupancy unchanged and preserve FIFO order.
REQ-025 SHALL hold m_data stable while m_valid && !m_ready.
REQ-026 SHALL update aempty_value to cfg_aempty on the cycle after cfg_load; ignore cfg_load in no state.
REQ-027 SHALL set err_underflow on underflow input high; cleared only by hw_rst or sw_rst.
REQ-028 SHALL treat sw_rst as priority over all else: buffer and in-flight data discarded, state IDLE, read_enable low that cycle, aempty_value unchanged.

Reset
REQ-029 SHALL, while hw_rst low: read_enable=0, m_valid=0, m_data=0, busy=0, err_underflow=0, aempty_value=AEMPTY_DEF, state IDLE.
REQ-030 SHALL discard any read in flight when hw_rst asserts mid-operation; first read_enable no earlier than 2 cycles after hw_rst release.

Configuration
REQ-031 SHALL, with FRC_STATS_EN defined, add outputs words_out[15:0] (count of m_valid&&m_ready, saturating at 16'hFFFF) and stall_cnt[15:0] (RUN cycles with rdempty high, saturating); both cleared by hw_rst and sw_rst.
REQ-032 SHALL, without FRC_STATS_EN, omit both ports and counters; all other behaviour identical.

Verification
REQ-033 SHALL cover: hw_rst release, enable=1, FIFO holding 0x11,0x22,0x33, m_ready=1 -> m_data 0x11,0x22,0x33 on consecutive cycles, first m_valid 2 cycles after first read_enable.
REQ-034 SHALL cover: rd_level=1, rdempty=0 -> exactly one read_enable, none in next cycle, no underflow.
REQ-035 SHALL cover: m_ready=0 for 10 cycles, 8 words queued -> exactly 2 read_enables, m_data held 0x11, no data loss after m_ready=1.
REQ-036 SHALL cover: enable dropped with 2 words buffered -> DRAIN, both delivered, then IDLE, busy=0, no further read_enable.
REQ-037 SHALL cover: sw_rst mid-burst -> m_valid=0 next cycle, state IDLE, err_underflow=0, aempty_value kept (e.g. 9 after cfg_load 9).
REQ-038 SHALL cover (FRC_STATS_EN): 5 transfers and 3 stalled RUN cycles -> words_out=5, stall_cnt=3.

Source files
------------

// File: rtl/fifo_read_ctrl.sv
// rtl/fifo_read_ctrl.sv - FIFO read-side controller with 2-entry skid buffer; optional stats counters under FRC_STATS_EN
module fifo_read_ctrl #(
    parameter int         DATA_W     = 32,
    parameter int         LVL_W      = 6,
    parameter logic [4:0] AEMPTY_DEF = 5'd5
) (
    input  logic              rclk,
    input  logic              hw_rst,
    input  logic              sw_rst,
    input  logic              enable,
    input  logic              cfg_load,
    input  logic [4:0]        cfg_aempty,
    input  logic              rdempty,
    input  logic              rd_almost_empty,
    input  logic              underflow,
    input  logic [LVL_W-1:0]  rd_level,
    input  logic [DATA_W-1:0] read_data,
    output logic              read_enable,
    output logic [4:0]        aempty_value,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              err_underflow
`ifdef FRC_STATS_EN
    ,
    output logic [15:0]       words_out,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [1:0]        arm_q;
    logic              rd_inflight_q;
    logic [1:0]        occ_q;
    logic [DATA_W-1:0] buf0_q;
    logic [DATA_W-1:0] buf1_q;
    logic              xfer;
    logic              push;
    logic [2:0]        occ_after;
    logic              lvl_low;
    logic              unused_status;

    // The almost-empty flag is informational only; the controller paces reads from rd_level.
    assign unused_status = rd_almost_empty;

    assign xfer      = (occ_q != 2'd0) && m_ready;
    assign push      = rd_inflight_q;
    // Occupancy the buffer will hold after this cycle's capture and transfer settle.
    assign occ_after = {1'b0, occ_q} + {2'b00, rd_inflight_q} - {2'b00, xfer};
    // rdempty/rd_level do not yet reflect a pop issued last cycle, so one word left may already be taken.
    assign lvl_low   = (rd_level <= LVL_W'(1));

    assign read_enable = (state_q == ST_RUN) && enable && !sw_rst && arm_q[1] && !rdempty
                         && (occ_after < 3'd2) && !(rd_inflight_q && lvl_low);

    assign m_valid = (occ_q != 2'd0);
    assign m_data  = buf0_q;
    assign busy    = (state_q != ST_IDLE);

    // Next-state decode for the run/drain sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable) state_d = ST_RUN;
            ST_RUN:   if (!enable) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (enable)
                    state_d = ST_RUN;
                else if (!rd_inflight_q && (occ_q == 2'd0))
                    state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Holds off the first read for two cycles after hard reset release.
    always_ff @(posedge rclk or negedge hw_rst) begin
        if (!hw_rst)
            arm_q <= 2'b00;
        else
            arm_q <= {arm_q[0], 1'b1};
    end

    // State, in-flight tracking and the skid buffer; head entry drives m_data.
    always_ff @(posedge rclk or negedge hw_rst) begin
        if (!hw_rst) begin
            state_q       <= ST_IDLE;
            rd_inflight_q <= 1'b0;
            occ_q         <= 2'd0;
            buf0_q        <= '0;
            buf1_q        <= '0;
        end else if (sw_rst) begin
            state_q       <= ST_IDLE;
            rd_inflight_q <= 1'b0;
            occ_q         <= 2'd0;
            buf0_q        <= '0;
            buf1_q        <= '0;
        end else begin
            state_q       <= state_d;
            rd_inflight_q <= read_enable;
            occ_q         <= occ_after[1:0];
            case ({push, xfer})
                2'b11: begin
                    if (occ_q == 2'd2) begin
                        buf0_q <= buf1_q;
                        buf1_q <= read_data;
                    end else begin
                        buf0_q <= read_data;
                    end
                end
                2'b10: begin
                    if (occ_q == 2'd0)
                        buf0_q <= read_data;
                    else
                        buf1_q <= read_data;
                end
                2'b01:   buf0_q <= buf1_q;
                default: ;
            endcase
        end
    end

    // Almost-empty threshold register; soft clear leaves it alone.
    always_ff @(posedge rclk or negedge hw_rst) begin
        if (!hw_rst)
            aempty_value <= AEMPTY_DEF;
        else if (cfg_load)
            aempty_value <= cfg_aempty;
    end

    // Sticky underflow flag.
    always_ff @(posedge rclk or negedge hw_rst) begin
        if (!hw_rst)
            err_underflow <= 1'b0;
        else if (sw_rst)
            err_underflow <= 1'b0;
        else if (underflow)
            err_underflow <= 1'b1;
    end

`ifdef FRC_STATS_EN
    // Saturating counts of delivered words and RUN cycles starved by an empty FIFO.
    always_ff @(posedge rclk or negedge hw_rst) begin
        if (!hw_rst) begin
            words_out <= 16'h0000;
            stall_cnt <= 16'h0000;
        end else if (sw_rst) begin
            words_out <= 16'h0000;
            stall_cnt <= 16'h0000;
        end else begin
            if (m_valid && m_ready && (words_out != 16'hFFFF))
                words_out <= words_out + 16'd1;
            if ((state_q == ST_RUN) && rdempty && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
